// File: rtl/gpio_box_mc.sv
// GPIO command bridge: toggle-handshaked commands drive the DAC, LED, ADC readback select and the reset pulse.
// Define GPIO_BOX_ADC_AVG_EN to replace the snapshot readback with a 2^AVG_LOG2-sample boxcar average.
module gpio_box_mc #(
    parameter int unsigned GPIO_WIDTH    = 32,
    parameter int unsigned ADC_WIDTH     = 12,
    parameter int unsigned DAC_WIDTH     = 14,
    parameter int unsigned N_CH          = 2,
    parameter int unsigned LED_VAL_WIDTH = 8,
    parameter int unsigned PULSE_MAX_W   = 16,
    parameter int unsigned AVG_LOG2      = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [GPIO_WIDTH-1:0]         gp_in,
    input  logic [N_CH*ADC_WIDTH-1:0]     adc_data,
    input  logic                          adc_valid,
    output logic [GPIO_WIDTH-1:0]         gp_out,
    output logic [N_CH*DAC_WIDTH-1:0]     dac_data,
    output logic                          dac_update,
    output logic [LED_VAL_WIDTH-1:0]      led_out,
    output logic                          pulse_rst
);

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_SHADOW = 3'd1,
        OP_COMMIT = 3'd2,
        OP_DIRECT = 3'd3,
        OP_ADCSEL = 3'd4,
        OP_LED    = 3'd5,
        OP_PULSE  = 3'd6,
        OP_RSVD   = 3'd7
    } op_e;

    typedef enum logic {
        P_IDLE   = 1'b0,
        P_ACTIVE = 1'b1
    } pstate_e;

    localparam logic [4:0] N_CH_W = 5'(N_CH);

    logic [GPIO_WIDTH-1:0]     gp_q;
    logic                      tog_q;
    logic                      ack_q;
    logic                      err_q;
    logic [3:0]                rd_ch_q;
    logic [N_CH*DAC_WIDTH-1:0] shadow_q;
    logic [N_CH*DAC_WIDTH-1:0] dac_q;
    logic                      dac_upd_q;
    logic [LED_VAL_WIDTH-1:0]  led_q;
    logic [ADC_WIDTH-1:0]      sample_q;
    pstate_e                   state_q;
    logic [PULSE_MAX_W-1:0]    cnt_q;
    logic                      pulse_q;

    logic                      fire;
    op_e                       op;
    logic [3:0]                ch;
    logic [23:0]               cmd_data;
    logic                      ch_ok;
    logic                      pulse_go;
    logic [PULSE_MAX_W-1:0]    plen;
    logic [ADC_WIDTH-1:0]      sel_sample;
    logic                      unused_ok;

    assign fire     = gp_q[31] ^ tog_q;
    assign op       = op_e'(gp_q[30:28]);
    assign ch       = gp_q[27:24];
    assign cmd_data = gp_q[23:0];
    assign ch_ok    = ({1'b0, ch} < N_CH_W);
    assign pulse_go = fire && (op == OP_PULSE);
    assign plen     = cmd_data[PULSE_MAX_W-1:0];

    // Command decode and execution; each TOG edge executes exactly once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gp_q      <= '0;
            tog_q     <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rd_ch_q   <= '0;
            shadow_q  <= '0;
            dac_q     <= '0;
            dac_upd_q <= 1'b0;
            led_q     <= '0;
        end else begin
            gp_q      <= gp_in;
            dac_upd_q <= 1'b0;
            if (fire) begin
                tog_q <= gp_q[31];
                ack_q <= gp_q[31];
                case (op)
                    OP_NOP: begin
                        if (cmd_data[0]) err_q <= 1'b0;
                    end
                    OP_SHADOW: begin
                        if (ch_ok) begin
                            for (int unsigned i = 0; i < N_CH; i++) begin
                                if (ch == 4'(i))
                                    shadow_q[i*DAC_WIDTH +: DAC_WIDTH] <= cmd_data[DAC_WIDTH-1:0];
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    OP_COMMIT: begin
                        dac_q     <= shadow_q;
                        dac_upd_q <= 1'b1;
                    end
                    OP_DIRECT: begin
                        if (ch_ok) begin
                            for (int unsigned i = 0; i < N_CH; i++) begin
                                if (ch == 4'(i)) begin
                                    shadow_q[i*DAC_WIDTH +: DAC_WIDTH] <= cmd_data[DAC_WIDTH-1:0];
                                    dac_q[i*DAC_WIDTH +: DAC_WIDTH]    <= cmd_data[DAC_WIDTH-1:0];
                                end
                            end
                            dac_upd_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    OP_ADCSEL: begin
                        if (ch_ok) rd_ch_q <= ch;
                        else       err_q   <= 1'b1;
                    end
                    OP_LED: begin
                        led_q <= cmd_data[LED_VAL_WIDTH-1:0];
                    end
                    OP_PULSE: begin
                    end
                    OP_RSVD: begin
                        err_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Pulse FSM: high for L cycles starting at the execute edge; a new PULSE reloads the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= P_IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else if (pulse_go) begin
            state_q <= P_ACTIVE;
            pulse_q <= 1'b1;
            cnt_q   <= (plen == '0) ? '0 : plen - PULSE_MAX_W'(1);
        end else begin
            case (state_q)
                P_IDLE: begin
                    pulse_q <= 1'b0;
                end
                P_ACTIVE: begin
                    if (cnt_q == '0) begin
                        state_q <= P_IDLE;
                        pulse_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - PULSE_MAX_W'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        sel_sample = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (rd_ch_q == 4'(i)) sel_sample = adc_data[i*ADC_WIDTH +: ADC_WIDTH];
        end
    end

`ifdef GPIO_BOX_ADC_AVG_EN
    localparam int unsigned ACC_W = ADC_WIDTH + AVG_LOG2;
    localparam logic [AVG_LOG2:0] AVG_LAST = (AVG_LOG2+1)'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    acc_sum;
    logic [AVG_LOG2:0]   avg_cnt_q;
    logic                avg_clr;

    assign acc_sum   = acc_q + ACC_W'(sel_sample);
    assign avg_clr   = fire && (op == OP_ADCSEL) && ch_ok;
    assign unused_ok = ^cmd_data;

    // A channel change restarts the window; the previous average stays visible until it fills.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            avg_cnt_q <= '0;
            sample_q  <= '0;
        end else if (avg_clr) begin
            acc_q     <= '0;
            avg_cnt_q <= '0;
        end else if (adc_valid) begin
            if (avg_cnt_q == AVG_LAST) begin
                sample_q  <= acc_sum[ACC_W-1:AVG_LOG2];
                acc_q     <= '0;
                avg_cnt_q <= '0;
            end else begin
                acc_q     <= acc_sum;
                avg_cnt_q <= avg_cnt_q + (AVG_LOG2+1)'(1);
            end
        end
    end
`else
    assign unused_ok = ^{cmd_data, 32'(AVG_LOG2)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q <= '0;
        end else if (adc_valid) begin
            sample_q <= sel_sample;
        end
    end
`endif

    assign gp_out     = {ack_q, (state_q == P_ACTIVE), err_q, 1'b0, rd_ch_q, 24'(sample_q)};
    assign dac_data   = dac_q;
    assign dac_update = dac_upd_q;
    assign led_out    = led_q;
    assign pulse_rst  = pulse_q;

endmodule
